// File: rtl/ex_commit_ctrl_pkg.sv
// rtl/ex_commit_ctrl_pkg.sv - shared types and constants for the exception/ERTN commit controller
package ex_commit_ctrl_pkg;

  localparam int WB2CSR_LEN = 81;

  localparam logic [5:0] ECODE_INT     = 6'h00;
  localparam logic [5:0] ECODE_ADE     = 6'h08;
  localparam logic [5:0] ECODE_ALE     = 6'h09;
  localparam logic [8:0] ESUBCODE_ADEF = 9'h000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COMMIT   = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  typedef enum logic {
    KIND_EX   = 1'b0,
    KIND_ERTN = 1'b1
  } kind_t;

  typedef struct packed {
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic [31:0] pc;
    logic [31:0] vaddr;
  } ev_fields_t;

  // Bus layout: {ertn_flush, wb_ex, ecode, esubcode, pc, vaddr}
  function automatic logic [WB2CSR_LEN-1:0] pack_bus(input logic ertn_flush,
                                                     input logic ex,
                                                     input ev_fields_t f);
    return {ertn_flush, ex, f.ecode, f.esubcode, f.pc, f.vaddr};
  endfunction

endpackage

// File: rtl/ex_prio_sel.sv
// rtl/ex_prio_sel.sv - fixed-priority event selector: interrupt > exception > ERTN
module ex_prio_sel
  import ex_commit_ctrl_pkg::*;
#(
  parameter logic [5:0] INT_ECODE = 6'h00
) (
  input  logic        valid,
  input  logic        has_int,
  input  logic        ex,
  input  logic        ertn,
  input  logic [5:0]  ecode,
  input  logic [8:0]  esubcode,
  input  logic [31:0] pc,
  input  logic [31:0] vaddr,
  output logic        sel,
  output kind_t       kind,
  output ev_fields_t  fields
);

  always_comb begin
    sel    = 1'b0;
    kind   = KIND_EX;
    fields = '0;
    if (valid) begin
      if (has_int) begin
        sel          = 1'b1;
        kind         = KIND_EX;
        fields.ecode = INT_ECODE;
        fields.pc    = pc;
      end else if (ex) begin
        sel             = 1'b1;
        kind            = KIND_EX;
        fields.ecode    = ecode;
        fields.esubcode = esubcode;
        fields.pc       = pc;
        fields.vaddr    = vaddr;
      end else if (ertn) begin
        sel       = 1'b1;
        kind      = KIND_ERTN;
        fields.pc = pc;
      end
    end
  end

endmodule

// File: rtl/ex_commit_ctrl.sv
// rtl/ex_commit_ctrl.sv - sequences exception/interrupt/ERTN commits to the CSR file and fetch redirect
// Optional commit counters enabled by defining EX_COMMIT_CNT_EN.
module ex_commit_ctrl #(
  parameter logic [5:0] ECODE_INT = 6'h00,
  parameter int         CNT_W     = 32
) (
  input  logic                                     clk,
  input  logic                                     resetn,
  input  logic                                     wb_valid,
  input  logic                                     wb_ex,
  input  logic [5:0]                               wb_ecode,
  input  logic [8:0]                               wb_esubcode,
  input  logic                                     wb_ertn,
  input  logic [31:0]                              wb_pc,
  input  logic [31:0]                              wb_vaddr,
  input  logic                                     has_int,
  input  logic [31:0]                              ex_entry,
  input  logic [31:0]                              era_pc,
  output logic [ex_commit_ctrl_pkg::WB2CSR_LEN-1:0] csr_in_bus,
  output logic                                     flush,
  output logic                                     wb_allowin,
  output logic                                     redirect_valid,
  output logic [31:0]                              redirect_pc,
  input  logic                                     redirect_ready,
  output logic [CNT_W-1:0]                         exc_count,
  output logic [CNT_W-1:0]                         ertn_count
);

  import ex_commit_ctrl_pkg::*;

  state_t     state, state_nxt;
  kind_t      kind_q, sel_kind;
  ev_fields_t fields_q, sel_fields;
  logic       sel;
  logic [31:0] redirect_pc_q;

  ex_prio_sel #(.INT_ECODE(ECODE_INT)) u_prio_sel (
    .valid    (wb_valid),
    .has_int  (has_int),
    .ex       (wb_ex),
    .ertn     (wb_ertn),
    .ecode    (wb_ecode),
    .esubcode (wb_esubcode),
    .pc       (wb_pc),
    .vaddr    (wb_vaddr),
    .sel      (sel),
    .kind     (sel_kind),
    .fields   (sel_fields)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (sel) state_nxt = ST_COMMIT;
      ST_COMMIT:   state_nxt = ST_REDIRECT;
      ST_REDIRECT: if (redirect_ready) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    csr_in_bus     = '0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    wb_allowin     = 1'b0;
    case (state)
      ST_IDLE:     wb_allowin = 1'b1;
      ST_COMMIT: begin
        csr_in_bus = pack_bus(kind_q == KIND_ERTN, kind_q == KIND_EX, fields_q);
        flush      = 1'b1;
      end
      ST_REDIRECT: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
      end
      default:     wb_allowin = 1'b1;
    endcase
  end

  // Redirect target is captured in COMMIT, before the ERA write lands
  always_ff @(posedge clk) begin
    if (!resetn) begin
      kind_q        <= KIND_EX;
      fields_q      <= '0;
      redirect_pc_q <= '0;
    end else begin
      if (state == ST_IDLE && sel) begin
        kind_q   <= sel_kind;
        fields_q <= sel_fields;
      end
      if (state == ST_COMMIT)
        redirect_pc_q <= (kind_q == KIND_ERTN) ? era_pc : ex_entry;
    end
  end

  assign redirect_pc = redirect_pc_q;

`ifdef EX_COMMIT_CNT_EN
  logic [CNT_W-1:0] exc_cnt_q, ertn_cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      exc_cnt_q  <= '0;
      ertn_cnt_q <= '0;
    end else if (state == ST_COMMIT) begin
      if (kind_q == KIND_EX && exc_cnt_q != '1)
        exc_cnt_q <= exc_cnt_q + 1'b1;
      if (kind_q == KIND_ERTN && ertn_cnt_q != '1)
        ertn_cnt_q <= ertn_cnt_q + 1'b1;
    end
  end

  assign exc_count  = exc_cnt_q;
  assign ertn_count = ertn_cnt_q;
`else
  assign exc_count  = '0;
  assign ertn_count = '0;
`endif

endmodule

// File: tb/tb_ex_commit_ctrl.sv
// tb/tb_ex_commit_ctrl.sv - directed self-checking bench for ex_commit_ctrl
module tb_ex_commit_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_valid, wb_ex, wb_ertn, has_int, redirect_ready;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc, wb_vaddr, ex_entry, era_pc;
  logic [80:0] csr_in_bus;
  logic        flush, wb_allowin, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] exc_count, ertn_count;

  int checks = 0;
  int errors = 0;

  ex_commit_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .wb_valid       (wb_valid),
    .wb_ex          (wb_ex),
    .wb_ecode       (wb_ecode),
    .wb_esubcode    (wb_esubcode),
    .wb_ertn        (wb_ertn),
    .wb_pc          (wb_pc),
    .wb_vaddr       (wb_vaddr),
    .has_int        (has_int),
    .ex_entry       (ex_entry),
    .era_pc         (era_pc),
    .csr_in_bus     (csr_in_bus),
    .flush          (flush),
    .wb_allowin     (wb_allowin),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .exc_count      (exc_count),
    .ertn_count     (ertn_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [80:0] obs, input logic [80:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_wb();
    wb_valid = 0; wb_ex = 0; wb_ertn = 0; has_int = 0;
    wb_ecode = '0; wb_esubcode = '0; wb_pc = '0; wb_vaddr = '0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_bus"}, csr_in_bus, 81'd0);
    chk({tag, "_flush"}, {80'd0, flush}, 81'd0);
    chk({tag, "_rv"}, {80'd0, redirect_valid}, 81'd0);
    chk({tag, "_allowin"}, {80'd0, wb_allowin}, 81'd1);
  endtask

  // One full event: pulse in IDLE, then COMMIT, then REDIRECT accepted immediately
  task automatic do_event(input logic ertn);
    wb_valid = 1; wb_ex = ~ertn; wb_ertn = ertn; wb_ecode = 6'h0B; wb_pc = 32'h1C000300;
    step();
    clear_wb();
    redirect_ready = 1;
    step();
    step();
  endtask

  initial begin
    clear_wb();
    resetn = 0; redirect_ready = 0;
    ex_entry = 32'h1C008000; era_pc = 32'h1C000104;
    @(negedge clk);
    step();
    chk_idle("reset");
    chk("reset_rpc", {49'd0, redirect_pc}, 81'd0);
    chk("reset_exc_cnt", {49'd0, exc_count}, 81'd0);
    chk("reset_ertn_cnt", {49'd0, ertn_count}, 81'd0);
    resetn = 1;
    step();

    // Syscall
    wb_valid = 1; wb_ex = 1; wb_ecode = 6'h0B; wb_pc = 32'h1C000100; wb_vaddr = 32'h12345678;
    step();
    clear_wb();
    chk("sys_commit_bus", csr_in_bus, {2'b01, 6'h0B, 9'h000, 32'h1C000100, 32'h12345678});
    chk("sys_commit_flush", {80'd0, flush}, 81'd1);
    chk("sys_commit_rv", {80'd0, redirect_valid}, 81'd0);
    chk("sys_commit_allowin", {80'd0, wb_allowin}, 81'd0);
    step();
    chk("sys_redir_rv", {80'd0, redirect_valid}, 81'd1);
    chk("sys_redir_pc", {49'd0, redirect_pc}, {49'd0, 32'h1C008000});
    chk("sys_redir_flush", {80'd0, flush}, 81'd1);
    chk("sys_redir_bus", csr_in_bus, 81'd0);
    redirect_ready = 1;
    step();
    chk_idle("sys_done");

    // ERTN; ERA changes after the commit edge must not affect the target
    wb_valid = 1; wb_ertn = 1; wb_pc = 32'h1C000050;
    step();
    clear_wb();
    chk("ertn_commit_flags", {79'd0, csr_in_bus[80:79]}, 81'd2);
    chk("ertn_commit_flush", {80'd0, flush}, 81'd1);
    step();
    era_pc = 32'h1C000999;
    chk("ertn_redir_pc", {49'd0, redirect_pc}, {49'd0, 32'h1C000104});
    chk("ertn_redir_rv", {80'd0, redirect_valid}, 81'd1);
    step();
    chk_idle("ertn_done");

    // Interrupt beats exception; then redirect stall with new events ignored
    redirect_ready = 0;
    has_int = 1; wb_valid = 1; wb_ex = 1; wb_ecode = 6'h09; wb_esubcode = 9'h005;
    wb_pc = 32'h1C000200; wb_vaddr = 32'h0000DEAD;
    step();
    clear_wb();
    chk("int_commit_bus", csr_in_bus, {2'b01, 6'h00, 9'h000, 32'h1C000200, 32'h00000000});
    ex_entry = 32'h1C00A000;
    step();
    ex_entry = 32'h1C00B000;
    wb_valid = 1; wb_ex = 1; wb_ecode = 6'h0B; wb_pc = 32'h1C000400;
    for (int i = 0; i < 5; i++) begin
      chk("stall_rv", {80'd0, redirect_valid}, 81'd1);
      chk("stall_flush", {80'd0, flush}, 81'd1);
      chk("stall_rpc", {49'd0, redirect_pc}, {49'd0, 32'h1C00A000});
      chk("stall_allowin", {80'd0, wb_allowin}, 81'd0);
      chk("stall_bus", csr_in_bus, 81'd0);
      step();
    end
    clear_wb();
    redirect_ready = 1;
    step();
    chk_idle("stall_done");
    step();
    chk_idle("stall_no_replay");

    // has_int without a retiring instruction is ignored
    has_int = 1; wb_ex = 1; wb_valid = 0;
    step();
    chk_idle("int_novalid_1");
    step();
    chk_idle("int_novalid_2");
    clear_wb();

    // Reset in the middle of REDIRECT
    redirect_ready = 0;
    wb_valid = 1; wb_ex = 1; wb_ecode = 6'h08; wb_pc = 32'h1C000500;
    step();
    clear_wb();
    step();
    chk("pre_reset_rv", {80'd0, redirect_valid}, 81'd1);
    resetn = 0;
    step();
    chk_idle("midreset");
    chk("midreset_rpc", {49'd0, redirect_pc}, 81'd0);
    chk("midreset_exc_cnt", {49'd0, exc_count}, 81'd0);
    resetn = 1;
    redirect_ready = 1;
    step();
    chk_idle("post_reset");

    // Counters: 3 exceptions and 2 ERTNs
    do_event(1'b0);
    do_event(1'b1);
    do_event(1'b0);
    do_event(1'b1);
    do_event(1'b0);
`ifdef EX_COMMIT_CNT_EN
    chk("exc_count", {49'd0, exc_count}, 81'd3);
    chk("ertn_count", {49'd0, ertn_count}, 81'd2);
`else
    chk("exc_count", {49'd0, exc_count}, 81'd0);
    chk("ertn_count", {49'd0, ertn_count}, 81'd0);
`endif
    chk_idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_commit_ctrl.md
Name: ex_commit_ctrl

Overview:
- Sequences exception, interrupt and ERTN commits between the writeback stage, the CSR file and the fetch stage.
- Selects the winning event for each retiring instruction, drives the one-cycle `wb_ex`/`ertn_flush` commit on the CSR input bus, flushes the pipeline, and holds a redirect to fetch until fetch accepts it.
- Sits beside the CSR file in the CPU top and is its sole source of `CSR_in_bus`.

Parameters:
- ECODE_INT, 6'h00, ecode written for an interrupt.
- CNT_W, 32, width of the commit counters (used only with the optional feature).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- wb_valid  in  1  writeback stage holds a valid instruction this cycle
- wb_ex  in  1  writeback instruction carries an exception
- wb_ecode  in  6  exception code
- wb_esubcode  in  9  exception subcode
- wb_ertn  in  1  writeback instruction is ERTN
- wb_pc  in  32  writeback PC
- wb_vaddr  in  32  faulting data address
- has_int  in  1  pending enabled interrupt, from the CSR file
- ex_entry  in  32  exception entry address, from the CSR file
- era_pc  in  32  ERA value, from the CSR file
- csr_in_bus  out  WB2CSR_LEN(81)  {ertn_flush, wb_ex, ecode, esubcode, pc, vaddr}
- flush  out  1  kill all instructions in IF..WB
- wb_allowin  out  1  writeback may accept/retire an instruction
- redirect_valid  out  1  fetch redirect request
- redirect_pc  out  32  fetch redirect target
- redirect_ready  in  1  fetch accepts the redirect
- exc_count  out  CNT_W  exceptions+interrupts taken (optional feature)
- ertn_count  out  CNT_W  ERTNs taken (optional feature)

Behaviour:
- State machine: IDLE, COMMIT, REDIRECT.
- Reset (`resetn`=0 at a clock edge) gives:
  - state=IDLE
  - `csr_in_bus`=0, `flush`=0, `redirect_valid`=0, `redirect_pc`=0
  - `wb_allowin`=1, counters=0
- Reset wins over any state, including mid-REDIRECT; the pending redirect is dropped.
- Event selection happens in IDLE only, when `wb_valid`=1. Fixed priority:
  1. `has_int` → interrupt: ecode=ECODE_INT, esubcode=0, pc=`wb_pc`, vaddr=0.
  2. `wb_ex` → exception: fields taken from the wb_* inputs.
  3. `wb_ertn` → ERTN.
- Interrupts are taken only on a valid retiring instruction; `has_int` with `wb_valid`=0 is ignored.
- IDLE behaviour:
  - If an event is selected, latch the fields and the kind (EX or ERTN), then go to COMMIT.
  - Otherwise stay in IDLE; all outputs idle.
- COMMIT (exactly 1 cycle):
  - `csr_in_bus` carries the latched fields with `wb_ex`=1 (EX) or `ertn_flush`=1 (ERTN); never both.
  - `flush`=1.
  - Latch `redirect_pc`: `ex_entry` for EX, `era_pc` for ERTN. These are the CSR values in this cycle; EENTRY is not modified by a commit, and the ERA update becomes visible only after this edge.
  - Go to REDIRECT.
- REDIRECT:
  - `redirect_valid`=1 and `flush`=1; `csr_in_bus`=0.
  - `redirect_pc` is held stable.
  - On `redirect_valid` & `redirect_ready` → IDLE.
  - No timeout.
- `wb_allowin` = (state==IDLE). Writeback inputs are ignored outside IDLE.
- Latency: event sampled at edge N → CSR commit pulse during cycle N+1 → `redirect_valid` from cycle N+2. Back-to-back events need a minimum of 3 cycles each.
- `csr_in_bus` is zero in every cycle except COMMIT, so CSR state changes exactly once per event.
- `redirect_ready` high while not in REDIRECT has no effect.

Optional Feature:
- Macro: EX_COMMIT_CNT_EN.
- Defined:
  - `exc_count` increments on each COMMIT of kind EX; `ertn_count` on each COMMIT of kind ERTN.
  - Both saturate at all-ones and are cleared by reset.
- Undefined:
  - Both ports are tied to 0 and no counter registers exist.

Decomposition:
- Shared package/header holds:
  - WB2CSR_LEN
  - ECODE_INT, ECODE_ADE, ECODE_ALE, ESUBCODE_ADEF
  - state encoding (IDLE=2'd0, COMMIT=2'd1, REDIRECT=2'd2)
  - kind encoding (EX, ERTN)
- One natural sub-module, ex_prio_sel: a combinational priority selector that outputs the selected kind and the fields.

Test Plan:
- Syscall: `wb_valid`=1, `wb_ex`=1, ecode=6'h0B, `wb_pc`=0x1C000100, `ex_entry`=0x1C008000 → next cycle `csr_in_bus` has `wb_ex`=1, ecode 0x0B, pc 0x1C000100; following cycle `redirect_valid`=1, `redirect_pc`=0x1C008000; `flush`=1 for both cycles.
- ERTN: `wb_ertn`=1, `era_pc`=0x1C000104 → COMMIT pulses `ertn_flush`=1 only; `redirect_pc`=0x1C000104.
- Interrupt priority: `has_int`=1 with `wb_ex`=1 (ecode 0x09) at `wb_pc` 0x1C000200 → committed ecode=0x00, esubcode=0, pc=0x1C000200. Separately, `has_int`=1 with `wb_valid`=0 → no event.
- Redirect stall: hold `redirect_ready`=0 for 5 cycles → `redirect_valid`/`flush` stay 1, `redirect_pc` stable, `wb_allowin`=0, new wb events ignored; `ready`=1 → IDLE next cycle.
- Reset mid-REDIRECT: `resetn`=0 → next cycle all outputs 0, `wb_allowin`=1, state IDLE.
- With EX_COMMIT_CNT_EN: 3 exceptions and 2 ERTNs → `exc_count`=3, `ertn_count`=2. Without the macro, both read 0.
